// File: rtl/letc_pkg.sv
// Shared AXI types and helpers for the LETC SoC.
// Anything that decodes AXI bursts (SRAM subordinate, core AXI FSM) imports this package.
package letc_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef logic [2:0] axi_size_t;
  typedef logic [7:0] axi_len_t;

  localparam axi_size_t AXI_SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    SRAM_IDLE,
    SRAM_WDATA,
    SRAM_WRESP,
    SRAM_RDATA
  } sram_state_e;

  // A WRAP burst must span 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input axi_len_t len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 channel bundle (32-bit data) between a LETC manager and a subordinate.
// The ID width is set here; the modules on either side take it from this interface.
interface axi_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0]  awid;
  logic [31:0]          awaddr;
  letc_pkg::axi_len_t   awlen;
  letc_pkg::axi_size_t  awsize;
  logic [1:0]           awburst;
  logic                 awvalid;
  logic                 awready;

  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;

  logic [ID_WIDTH-1:0]  bid;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;

  logic [ID_WIDTH-1:0]  arid;
  logic [31:0]          araddr;
  letc_pkg::axi_len_t   arlen;
  letc_pkg::axi_size_t  arsize;
  logic [1:0]           arburst;
  logic                 arvalid;
  logic                 arready;

  logic [ID_WIDTH-1:0]  rid;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;

  modport subordinate (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport manager (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/letc_axi_burst_addr_gen.sv
// Combinational AXI burst address sequencer for 32-bit beats.
// Given the current beat address, it returns the next one and reports whether a WRAP length is legal.
module letc_axi_burst_addr_gen
  import letc_pkg::*;
(
  input  logic [31:0] addr,
  input  axi_len_t    len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        wrap_legal
);
  logic [31:0] incr;
  logic [31:0] mask;

  assign wrap_legal = wrap_len_ok(len);
  assign incr       = addr + 32'd4;
  // For a legal wrap length, (len+1)*4 - 1 is simply {len, 2'b11}.
  assign mask       = {26'd0, len[3:0], 2'b11};

  always_comb begin
    next_addr = addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/letc_axi_sram_sub.sv
// AXI4 subordinate backed by a word-addressed synchronous SRAM.
// It serves one read or write burst at a time and arbitrates AW and AR round-robin.
module letc_axi_sram_sub
  import letc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter string       INIT_FILE   = ""
) (
  input logic        i_clk,
  input logic        i_rst,
  axi_if.subordinate axi
);
  localparam int          IDW  = $bits(axi.awid);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) * 32'd4;

  function automatic logic in_range(input logic [31:0] a);
    return (a & ~(SPAN - 32'd1)) == BASE_ADDR;
  endfunction

  sram_state_e    state, state_next;
  logic           prio_w, grant_w;
  logic           aw_hs, ar_hs, w_hs, r_hs, w_final, ren;
  logic           req_bad, wrap_legal, beat_err, rd_err;
  logic [IDW-1:0] req_id, id_q;
  logic [31:0]    req_addr, addr_q, gen_addr, next_addr;
  axi_len_t       req_len, len_q, cnt_q, gen_len;
  axi_size_t      req_size;
  logic [1:0]     req_burst, burst_q, gen_burst;
  logic           req_err_q, err_q, rvalid_q, rlast_q, rerr_q;
  logic [AW-1:0]  rd_idx;
  logic [31:0]    ram_q;
  logic [31:0]    mem [DEPTH_WORDS];

  // In IDLE the selected request is fed through the generator to vet its wrap length.
  assign grant_w   = axi.awvalid & (~axi.arvalid | prio_w);
  assign req_id    = grant_w ? axi.awid    : axi.arid;
  assign req_addr  = grant_w ? {axi.awaddr[31:2], 2'b00} : {axi.araddr[31:2], 2'b00};
  assign req_len   = grant_w ? axi.awlen   : axi.arlen;
  assign req_size  = grant_w ? axi.awsize  : axi.arsize;
  assign req_burst = grant_w ? axi.awburst : axi.arburst;

  assign gen_addr  = (state == SRAM_IDLE) ? req_addr  : addr_q;
  assign gen_len   = (state == SRAM_IDLE) ? req_len   : len_q;
  assign gen_burst = (state == SRAM_IDLE) ? req_burst : burst_q;

  letc_axi_burst_addr_gen u_addr_gen (
    .addr       (gen_addr),
    .len        (gen_len),
    .burst      (gen_burst),
    .next_addr  (next_addr),
    .wrap_legal (wrap_legal)
  );

  assign req_bad  = (req_size != AXI_SIZE_WORD) | (req_burst == BURST_RSVD) |
                    ((req_burst == BURST_WRAP) & ~wrap_legal);
  assign aw_hs    = (state == SRAM_IDLE) & axi.awvalid & grant_w;
  assign ar_hs    = (state == SRAM_IDLE) & axi.arvalid & ~grant_w;
  assign w_hs     = (state == SRAM_WDATA) & axi.wvalid;
  assign w_final  = (cnt_q == len_q);
  assign beat_err = req_err_q | ~in_range(addr_q);
  assign r_hs     = (state == SRAM_RDATA) & rvalid_q & axi.rready;
  assign ren      = ar_hs | (r_hs & ~rlast_q);
  assign rd_idx   = ar_hs ? req_addr[AW+1:2] : next_addr[AW+1:2];
  assign rd_err   = ar_hs ? (req_bad | ~in_range(req_addr)) : (req_err_q | ~in_range(next_addr));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= SRAM_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    axi.awready = 1'b0;
    axi.arready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    case (state)
      SRAM_IDLE: begin
        axi.awready = axi.awvalid & grant_w;
        axi.arready = axi.arvalid & ~grant_w;
        if (aw_hs)      state_next = SRAM_WDATA;
        else if (ar_hs) state_next = SRAM_RDATA;
      end
      SRAM_WDATA: begin
        axi.wready = 1'b1;
        if (axi.wvalid && w_final) state_next = SRAM_WRESP;
      end
      SRAM_WRESP: begin
        axi.bvalid = 1'b1;
        if (axi.bready) state_next = SRAM_IDLE;
      end
      SRAM_RDATA: begin
        if (rvalid_q && axi.rready && rlast_q) state_next = SRAM_IDLE;
      end
      default: state_next = SRAM_IDLE;
    endcase
  end

  // Request latch, beat sequencing and the read-channel output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio_w    <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      req_err_q <= 1'b0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      if (state == SRAM_IDLE && axi.awvalid && axi.arvalid) prio_w <= ~prio_w;
      if (aw_hs || ar_hs) begin
        id_q      <= req_id;
        addr_q    <= req_addr;
        len_q     <= req_len;
        burst_q   <= req_burst;
        cnt_q     <= '0;
        req_err_q <= req_bad;
        err_q     <= req_bad;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rlast_q  <= (req_len == 8'd0);
        rerr_q   <= rd_err;
      end
      if (w_hs) begin
        addr_q <= next_addr;
        cnt_q  <= cnt_q + 8'd1;
        if (beat_err || (axi.wlast != w_final)) err_q <= 1'b1;
      end
      if (r_hs) begin
        if (rlast_q) begin
          rvalid_q <= 1'b0;
          rlast_q  <= 1'b0;
        end else begin
          addr_q  <= next_addr;
          cnt_q   <= cnt_q + 8'd1;
          rlast_q <= ((cnt_q + 8'd1) == len_q);
          rerr_q  <= rd_err;
        end
      end
    end
  end

  // Erroring beats, including ones that fall past the top of the array, never touch memory.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_hs && !beat_err) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.wstrb[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)    ram_q <= '0;
    else if (ren) ram_q <= mem[rd_idx];
  end

  assign axi.bid    = id_q;
  assign axi.bresp  = (state == SRAM_WRESP && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi.rid    = id_q;
  assign axi.rdata  = rerr_q ? 32'd0 : ram_q;
  assign axi.rresp  = rerr_q ? RESP_SLVERR : RESP_OKAY;
  assign axi.rvalid = rvalid_q;
  assign axi.rlast  = rlast_q;

endmodule
